seq_shift_unit: RTL

//  Multi-cycle shift unit for the MIPS datapath: SLL/SRL/SRA of a WIDTH-bit operand.

---
 rtl/seq_shift_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seq_shift_unit.sv
// ---------------------------------------------------------------------------
// seq_shift_unit
//   Multi-cycle shift unit for the MIPS datapath. Performs SLL, SRL or SRA of
//   a WIDTH-bit operand by a variable amount, one bit position per clock, so
//   no wide barrel array is needed. A start/busy/done handshake controls it.
//
// Parameters
//   WIDTH  operand/result width in bits
//   SHW    shift-amount width, equal to clog2(WIDTH)
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, sampled only in IDLE or DONE
//   op      in   2      00/10=SLL, 01=SRL, 11=SRA
//   data    in   WIDTH  operand, sampled on an accepted start
//   shamt   in   SHW    shift amount 0..WIDTH-1, sampled on an accepted start
//   busy    out  1      high while shifting
//   done    out  1      one-cycle pulse when result becomes valid
//   result  out  WIDTH  shifted value, held until the next done
// ---------------------------------------------------------------------------
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]     OP_SRL    = 2'b01;
    localparam logic [1:0]     OP_SRA    = 2'b11;
    localparam logic [SHW-1:0] CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ZERO  = '0;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_count;
    logic [1:0]       r_op_q;
    logic             r_sign_q;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_zero_shift;
    logic             w_last_step;
    logic [WIDTH-1:0] w_shifted;

    // A new request is only taken when the unit is not mid-shift; accepting
    // in DONE gives back-to-back operation without an idle bubble.
    assign w_accept     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_zero_shift = (shamt == CNT_ZERO);
    assign w_last_step  = (r_state == ST_SHIFT) && (r_count == CNT_ONE);

    // One-bit step of the accumulator. The SRA fill comes from the sign bit
    // captured at start, so later changes on data cannot leak in.
    always_comb begin
        w_shifted = {r_acc[WIDTH-2:0], 1'b0};
        case (r_op_q)
            OP_SRL:  w_shifted = {1'b0, r_acc[WIDTH-1:1]};
            OP_SRA:  w_shifted = {r_sign_q, r_acc[WIDTH-1:1]};
            default: w_shifted = {r_acc[WIDTH-2:0], 1'b0};
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    // A zero shift needs no stepping: report the operand directly.
                    w_state_next = w_zero_shift ? ST_DONE : ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last_step) begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath: operand capture, stepping and result update
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_op_q   <= '0;
            r_sign_q <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                if (w_zero_shift) begin
                    r_result <= data;
                end else begin
                    r_acc    <= data;
                    r_count  <= shamt;
                    r_op_q   <= op;
                    r_sign_q <= data[WIDTH-1];
                end
            end else if (r_state == ST_SHIFT) begin
                r_acc   <= w_shifted;
                r_count <= r_count - CNT_ONE;
                // Result moves only on the transition into DONE.
                if (w_last_step) begin
                    r_result <= w_shifted;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Registered Moore status flags, decoded from the next state so they
    // line up with the state they describe.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_SHIFT);
            r_done <= (w_state_next == ST_DONE);
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
